// File: rtl/seg_display_pkg.sv
// Shared constants for the seven-segment display driver: active-low hex font,
// the all-dark segment pattern and the digit-count limits.
package seg_display_pkg;

  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam int         MAX_DIGITS = 8;

  // Entry n is the {a,b,c,d,e,f,g,dp} pattern for hex digit n, 0 = lit.
  localparam logic [15:0][7:0] FONT = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_hex_font.sv
// Combinational 4-bit hex to active-low seven-segment decode; zero latency,
// no flow control.
module seg_hex_font
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = FONT[nibble];

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed N-digit common-anode driver, double buffered, registered outputs
// (1 clk tick->pins, no backpressure). Define SEG_DISPLAY_LZ_BLANK_EN for leading-zero blanking.
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int DIV_BITS   = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output logic                    frame_start,
  output logic [7:0]              seven_seg,
  output logic [NUM_DIGITS-1:0]   seven_seg_en
);

  localparam int             IW   = idx_width(NUM_DIGITS);
  localparam logic [IW-1:0]  LAST = IW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("seg_display_mux: NUM_DIGITS out of range");
  end

  logic [DIV_BITS-1:0]     presc;
  logic                    tick;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idx_nxt;
  logic                    scanning;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] sh_value,   disp_value,   disp_value_nxt;
  logic [NUM_DIGITS-1:0]   sh_dp,      disp_dp,      disp_dp_nxt;
  logic [NUM_DIGITS-1:0]   sh_blank,   disp_blank,   disp_blank_nxt;

  logic [3:0]              nib;
  logic                    dp_bit;
  logic [7:0]              font_seg;
  logic [7:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   en_nxt;

  assign tick = &presc;

  // The first tick after reset starts a frame at digit 0, so the scan always
  // opens on the rightmost digit with a freshly loaded buffer.
  assign wrap    = !scanning || (idx == LAST);
  assign idx_nxt = wrap ? '0 : idx + 1'b1;

  assign disp_value_nxt = wrap ? sh_value : disp_value;
  assign disp_dp_nxt    = wrap ? sh_dp    : disp_dp;
  assign disp_blank_nxt = wrap ? sh_blank : disp_blank;

  assign nib    = 4'(disp_value_nxt >> (4 * idx_nxt));
  assign dp_bit = disp_dp_nxt[idx_nxt];
  assign en_nxt = ~(NUM_DIGITS'(1) << idx_nxt);

  seg_hex_font u_font (
    .nibble (nib),
    .seg    (font_seg)
  );

`ifdef SEG_DISPLAY_LZ_BLANK_EN
  logic lz_dark;

  // Digit is a leading zero when it and everything to its left are zero.
  always_comb begin
    lz_dark = 1'b0;
    if (idx_nxt != '0) begin
      lz_dark = ((disp_value_nxt >> (4 * idx_nxt)) == '0);
    end
  end

  always_comb begin
    seg_nxt = {font_seg[7:1], ~dp_bit};
    if (disp_blank_nxt[idx_nxt]) begin
      seg_nxt = SEG_OFF;
    end else if (lz_dark) begin
      seg_nxt = {7'h7F, ~dp_bit};
    end
  end
`else
  always_comb begin
    seg_nxt = {font_seg[7:1], ~dp_bit};
    if (disp_blank_nxt[idx_nxt]) begin
      seg_nxt = SEG_OFF;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      presc        <= '0;
      idx          <= '0;
      scanning     <= 1'b0;
      sh_value     <= '0;
      sh_dp        <= '0;
      sh_blank     <= '0;
      disp_value   <= '0;
      disp_dp      <= '0;
      disp_blank   <= '0;
      frame_start  <= 1'b0;
      seven_seg    <= SEG_OFF;
      seven_seg_en <= '1;
    end else begin
      presc       <= presc + 1'b1;
      frame_start <= 1'b0;
      if (load) begin
        sh_value <= value;
        sh_dp    <= dp;
        sh_blank <= blank;
      end
      if (tick) begin
        scanning     <= 1'b1;
        idx          <= idx_nxt;
        frame_start  <= wrap;
        seven_seg    <= seg_nxt;
        seven_seg_en <= en_nxt;
        // A load on the same edge lands in shadow only; this frame uses the old copy.
        if (wrap) begin
          disp_value <= sh_value;
          disp_dp    <= sh_dp;
          disp_blank <= sh_blank;
        end
      end
    end
  end

endmodule
